// File: rtl/eim_bridge_pkg.sv
// Shared types and constants for the EIM segment bridge.
package eim_bridge_pkg;

  localparam int unsigned SEG_MSB    = 16;
  localparam int unsigned SEG_LSB    = 14;
  localparam int unsigned REG_ADDR_W = 14;
  localparam int unsigned DATA_W     = 32;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WRITE     = 2'd1,
    ST_READ_WAIT = 2'd2,
    ST_CAPTURE   = 2'd3
  } state_t;

endpackage

// File: rtl/eim_segment_rd_mux.sv
// Registered NUM_SEGMENTS:1 read-word mux; out-of-range segments return UNMAPPED_DATA.
module eim_segment_rd_mux
  import eim_bridge_pkg::*;
#(
  parameter int unsigned       NUM_SEGMENTS  = 4,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = 32'hDEADBEEF
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             capture,
  input  logic [2:0]                       seg_idx,
  input  logic [NUM_SEGMENTS*DATA_W-1:0]   seg_read_data,
  output logic [DATA_W-1:0]                read_data,
  output logic                             read_valid
);

  logic [DATA_W-1:0] word;

  always_comb begin
    word = UNMAPPED_DATA;
    for (int unsigned i = 0; i < NUM_SEGMENTS; i++) begin
      if (32'(seg_idx) == i) word = seg_read_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      read_data  <= '0;
      read_valid <= 1'b0;
    end else begin
      read_valid <= capture;
      if (capture) read_data <= word;
    end
  end

endmodule

// File: rtl/eim_segment_bridge.sv
// EIM strobe to segment-select bridge with fixed read latency and sticky error flag.
// Optional error counter enabled by defining EIM_SEGMENT_BRIDGE_ERR_CNT_EN.
module eim_segment_bridge
  import eim_bridge_pkg::*;
#(
  parameter int unsigned       NUM_SEGMENTS  = 4,
  parameter int unsigned       READ_LATENCY  = 2,
  parameter logic [DATA_W-1:0] UNMAPPED_DATA = 32'hDEADBEEF
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst,
  input  logic [16:0]                    sys_eim_addr,
  input  logic                           sys_eim_wr,
  input  logic                           sys_eim_rd,
  input  logic [DATA_W-1:0]              sys_write_data,
  output logic [DATA_W-1:0]              sys_read_data,
  output logic                           sys_read_valid,
  output logic                           busy,
  output logic                           err,
  output logic [NUM_SEGMENTS-1:0]        seg_cs,
  output logic                           seg_we,
  output logic [REG_ADDR_W-1:0]          seg_addr,
  output logic [DATA_W-1:0]              seg_write_data,
  input  logic [NUM_SEGMENTS*DATA_W-1:0] seg_read_data,
  output logic [15:0]                    err_count
);

  state_t                  state, state_next;
  logic [3:0]              lat_cnt;
  logic [2:0]              seg_idx;
  logic [2:0]              strobe_idx;
  logic                    idle, strobe, mapped;
  logic                    accept_wr, accept_rd, err_event, capture;
  logic [NUM_SEGMENTS-1:0] cs_decode;

  assign strobe_idx = sys_eim_addr[SEG_MSB:SEG_LSB];
  assign idle       = (state == ST_IDLE);
  assign strobe     = sys_eim_wr | sys_eim_rd;
  assign mapped     = 32'(strobe_idx) < NUM_SEGMENTS;
  assign accept_wr  = idle & sys_eim_wr;
  // A collision is served as a write; the read half is dropped.
  assign accept_rd  = idle & sys_eim_rd & ~sys_eim_wr;
  assign err_event  = strobe & (~idle | (sys_eim_wr & sys_eim_rd) | ~mapped);

  always_comb begin
    cs_decode = '0;
    for (int unsigned i = 0; i < NUM_SEGMENTS; i++) begin
      if (32'(strobe_idx) == i) cs_decode[i] = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (accept_wr)      state_next = ST_WRITE;
        else if (accept_rd) state_next = ST_READ_WAIT;
      end
      ST_WRITE:     state_next = ST_IDLE;
      ST_READ_WAIT: if (lat_cnt == 4'd0) state_next = ST_CAPTURE;
      ST_CAPTURE:   state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == ST_READ_WAIT) || (state == ST_CAPTURE);
    capture = (state == ST_CAPTURE);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      seg_cs         <= '0;
      seg_we         <= 1'b0;
      seg_addr       <= '0;
      seg_write_data <= '0;
      seg_idx        <= '0;
      lat_cnt        <= '0;
      err            <= 1'b0;
    end else begin
      seg_cs <= '0;
      seg_we <= 1'b0;
      if (accept_wr || accept_rd) begin
        seg_cs   <= cs_decode;
        seg_we   <= accept_wr;
        seg_addr <= sys_eim_addr[REG_ADDR_W-1:0];
        seg_idx  <= strobe_idx;
      end
      if (accept_wr) seg_write_data <= sys_write_data;
      if (accept_rd) begin
        lat_cnt <= 4'(READ_LATENCY - 1);
      end else if (state == ST_READ_WAIT && lat_cnt != 4'd0) begin
        lat_cnt <= lat_cnt - 4'd1;
      end
      if (err_event) err <= 1'b1;
    end
  end

  eim_segment_rd_mux #(
    .NUM_SEGMENTS (NUM_SEGMENTS),
    .UNMAPPED_DATA(UNMAPPED_DATA)
  ) u_rd_mux (
    .clk          (sys_clk),
    .rst          (sys_rst),
    .capture      (capture),
    .seg_idx      (seg_idx),
    .seg_read_data(seg_read_data),
    .read_data    (sys_read_data),
    .read_valid   (sys_read_valid)
  );

`ifdef EIM_SEGMENT_BRIDGE_ERR_CNT_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst)                                   err_count <= '0;
    else if (err_event && err_count != 16'hFFFF)   err_count <= err_count + 16'd1;
  end
`else
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_eim_segment_bridge.sv
// Bench for eim_segment_bridge: directed vector table, corner sequences, random run vs. transaction model.
module tb_eim_segment_bridge;

  localparam int NS = 4;
  localparam int RL = 2;
  localparam logic [31:0] UNMAPPED = 32'hDEADBEEF;

  logic           clk = 1'b0;
  logic           sys_rst = 1'b1;
  logic [16:0]    sys_eim_addr = '0;
  logic           sys_eim_wr = 1'b0;
  logic           sys_eim_rd = 1'b0;
  logic [31:0]    sys_write_data = '0;
  logic [31:0]    sys_read_data;
  logic           sys_read_valid;
  logic           busy;
  logic           err;
  logic [NS-1:0]  seg_cs;
  logic           seg_we;
  logic [13:0]    seg_addr;
  logic [31:0]    seg_write_data;
  logic [NS*32-1:0] seg_read_data = '0;
  logic [15:0]    err_count;

  always #5 clk = ~clk;

  eim_segment_bridge #(
    .NUM_SEGMENTS (NS),
    .READ_LATENCY (RL),
    .UNMAPPED_DATA(UNMAPPED)
  ) dut (
    .sys_clk       (clk),
    .sys_rst       (sys_rst),
    .sys_eim_addr  (sys_eim_addr),
    .sys_eim_wr    (sys_eim_wr),
    .sys_eim_rd    (sys_eim_rd),
    .sys_write_data(sys_write_data),
    .sys_read_data (sys_read_data),
    .sys_read_valid(sys_read_valid),
    .busy          (busy),
    .err           (err),
    .seg_cs        (seg_cs),
    .seg_we        (seg_we),
    .seg_addr      (seg_addr),
    .seg_write_data(seg_write_data),
    .seg_read_data (seg_read_data),
    .err_count     (err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef EIM_SEGMENT_BRIDGE_ERR_CNT_EN
    return 32'(n);
`else
    return 32'(n * 0);
`endif
  endfunction

  // Segment environment: memories that answer exactly RL cycles after seg_cs.
  logic [31:0] env_mem [int];
  int ncnt = 0;
  int tgt = -1;
  int pend_seg = 0;
  int pend_key = 0;

  function automatic logic [31:0] init_word(input int key);
    return 32'(key) * 32'h9E3779B1 + 32'h1234;
  endfunction

  function automatic logic [31:0] env_rd(input int key);
    return env_mem.exists(key) ? env_mem[key] : init_word(key);
  endfunction

  always @(negedge clk) begin
    ncnt++;
    for (int i = 0; i < NS; i++) begin
      if (seg_cs[i]) begin
        if (seg_we) env_mem[i*16384 + int'(seg_addr)] = seg_write_data;
        else begin
          tgt = ncnt + RL;
          pend_seg = i;
          pend_key = i*16384 + int'(seg_addr);
        end
      end
    end
    for (int i = 0; i < NS; i++)
      seg_read_data[i*32 +: 32] = (ncnt == tgt && pend_seg == i) ? env_rd(pend_key)
                                                                 : (32'hBAD00000 | 32'(i));
  end

  task automatic do_reset();
    @(negedge clk);
    sys_rst = 1'b1; sys_eim_wr = 1'b0; sys_eim_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sys_rst = 1'b0;
  endtask

  task automatic check_reset_state(input int id);
    check($sformatf("rst_rdata[%0d]", id), sys_read_data, 32'h0);
    check($sformatf("rst_valid[%0d]", id), 32'(sys_read_valid), 32'h0);
    check($sformatf("rst_busy[%0d]", id), 32'(busy), 32'h0);
    check($sformatf("rst_err[%0d]", id), 32'(err), 32'h0);
    check($sformatf("rst_cs[%0d]", id), 32'(seg_cs), 32'h0);
    check($sformatf("rst_cnt[%0d]", id), 32'(err_count), 32'h0);
  endtask

  typedef struct {
    logic        wr, rd;
    logic [16:0] addr;
    logic [31:0] wdata, preload;
    logic [3:0]  e_cs;
    logic        e_we;
    logic [13:0] e_addr;
    logic [31:0] e_wd;
    int          e_lat;
    logic [31:0] e_rdata;
    int          e_busy;
    logic        e_err;
    int          e_ecnt;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic wr, input logic rd, input logic [16:0] addr,
                         input logic [31:0] wdata, input logic [31:0] preload,
                         input logic [3:0] e_cs, input logic e_we, input logic [13:0] e_addr,
                         input logic [31:0] e_wd, input int e_lat, input logic [31:0] e_rdata,
                         input int e_busy, input logic e_err, input int e_ecnt);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.preload = preload;
    v.e_cs = e_cs; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd; v.e_lat = e_lat;
    v.e_rdata = e_rdata; v.e_busy = e_busy; v.e_err = e_err; v.e_ecnt = e_ecnt;
    vq.push_back(v);
  endtask

  // Random-phase transaction model
  logic [3:0]  x_cs   [int];
  logic        x_we   [int];
  logic [13:0] x_addr [int];
  logic [31:0] x_wd   [int];
  logic [31:0] x_rd   [int];
  logic [31:0] ref_mem[int];

  initial begin
    logic [3:0]  cs1, oh;
    logic        we1, m_err, rw, rr, mapped, ev;
    logic [13:0] a1;
    logic [31:0] wd1, rdat, last_rd, wdr;
    logic [2:0]  seg;
    logic [16:0] ra;
    int pulses, busyc, lat, valids, free_at, m_cnt, busy_lo, busy_hi, key, r;

    add_vec(1, 0, 17'h0_4012, 32'hCAFEF00D, 32'h0,      4'b0010, 1, 14'h0012, 32'hCAFEF00D, 0, 32'h0,        0, 0, 0);
    add_vec(0, 1, 17'h0_C005, 32'h0,        32'h12345678, 4'b1000, 0, 14'h0005, 32'h0,      4, 32'h12345678, 3, 0, 0);
    add_vec(0, 1, 17'h1_C000, 32'h0,        32'h0,      4'b0000, 0, 14'h0000, 32'h0,        4, UNMAPPED,     3, 1, 1);
    add_vec(1, 1, 17'h0_4100, 32'h000055AA, 32'h0,      4'b0010, 1, 14'h0100, 32'h000055AA, 0, 32'h0,        0, 1, 1);
    add_vec(1, 0, 17'h1_0007, 32'h11112222, 32'h0,      4'b0000, 0, 14'h0000, 32'h0,        0, 32'h0,        0, 1, 1);
    add_vec(0, 1, 17'h0_0ABC, 32'h0,        32'hA5A50F0F, 4'b0001, 0, 14'h0ABC, 32'h0,      4, 32'hA5A50F0F, 3, 0, 0);

    for (int v = 0; v < vq.size(); v++) begin
      do_reset();
      check_reset_state(v);
      if (vq[v].rd && !vq[v].wr && vq[v].addr[16:14] < 3'(NS))
        env_mem[int'(vq[v].addr[16:14])*16384 + int'(vq[v].addr[13:0])] = vq[v].preload;
      sys_eim_wr = vq[v].wr; sys_eim_rd = vq[v].rd;
      sys_eim_addr = vq[v].addr; sys_write_data = vq[v].wdata;
      @(negedge clk);
      sys_eim_wr = 1'b0; sys_eim_rd = 1'b0;
      cs1 = seg_cs; we1 = seg_we; a1 = seg_addr; wd1 = seg_write_data;
      pulses = 0; busyc = 0; lat = 0; valids = 0; rdat = '0;
      for (int k = 1; k <= 10; k++) begin
        if (seg_cs != 0) pulses++;
        if (busy) busyc++;
        if (sys_read_valid) begin valids++; lat = k; rdat = sys_read_data; end
        @(negedge clk);
      end
      check($sformatf("vec%0d_cs", v), 32'(cs1), 32'(vq[v].e_cs));
      check($sformatf("vec%0d_cs_pulses", v), 32'(pulses), (vq[v].e_cs != 0) ? 32'd1 : 32'd0);
      if (vq[v].e_cs != 0) begin
        check($sformatf("vec%0d_we", v), 32'(we1), 32'(vq[v].e_we));
        check($sformatf("vec%0d_addr", v), 32'(a1), 32'(vq[v].e_addr));
      end
      if (vq[v].e_we) check($sformatf("vec%0d_wdata", v), wd1, vq[v].e_wd);
      check($sformatf("vec%0d_valids", v), 32'(valids), (vq[v].e_lat != 0) ? 32'd1 : 32'd0);
      check($sformatf("vec%0d_latency", v), 32'(lat), 32'(vq[v].e_lat));
      if (vq[v].e_lat != 0) begin
        check($sformatf("vec%0d_rdata", v), rdat, vq[v].e_rdata);
        check($sformatf("vec%0d_rdata_held", v), sys_read_data, vq[v].e_rdata);
      end
      check($sformatf("vec%0d_busy_cycles", v), 32'(busyc), 32'(vq[v].e_busy));
      check($sformatf("vec%0d_err", v), 32'(err), 32'(vq[v].e_err));
      check($sformatf("vec%0d_err_count", v), 32'(err_count), exp_cnt(vq[v].e_ecnt));
    end

    // Second read strobe one cycle after the first is an overrun.
    do_reset();
    env_mem[2*16384 + 3] = 32'h600DF00D;
    sys_eim_rd = 1'b1; sys_eim_addr = 17'h0_8003;
    @(negedge clk);
    pulses = (seg_cs != 0) ? 1 : 0; valids = 0; lat = 0;
    sys_eim_addr = 17'h0_4001;
    @(negedge clk);
    sys_eim_rd = 1'b0;
    for (int k = 2; k <= 10; k++) begin
      if (seg_cs != 0) pulses++;
      if (sys_read_valid) begin valids++; lat = k; rdat = sys_read_data; end
      @(negedge clk);
    end
    check("overrun_cs_pulses", 32'(pulses), 32'd1);
    check("overrun_valids", 32'(valids), 32'd1);
    check("overrun_latency", 32'(lat), 32'd4);
    check("overrun_rdata", rdat, 32'h600DF00D);
    check("overrun_err", 32'(err), 32'd1);
    check("overrun_err_count", 32'(err_count), exp_cnt(1));

    // Reset in the middle of a read aborts it and clears the held word.
    do_reset();
    env_mem[3*16384 + 5] = 32'h77778888;
    sys_eim_rd = 1'b1; sys_eim_addr = 17'h0_C005;
    @(negedge clk);
    sys_eim_rd = 1'b0;
    repeat (4) @(negedge clk);
    check("midrst_first_read", sys_read_data, 32'h77778888);
    sys_eim_rd = 1'b1; sys_eim_addr = 17'h0_8003;
    @(negedge clk);
    sys_eim_rd = 1'b0;
    check("midrst_busy_before", 32'(busy), 32'd1);
    sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rdata", sys_read_data, 32'h0);
    valids = 0; busyc = 0;
    for (int k = 0; k < 10; k++) begin
      if (sys_read_valid) valids++;
      if (busy) busyc++;
      @(negedge clk);
    end
    check("midrst_no_valid", 32'(valids), 32'd0);
    check("midrst_no_busy", 32'(busyc), 32'd0);
    check("midrst_rdata_after", sys_read_data, 32'h0);

    // Writes may issue every second cycle without error.
    do_reset();
    sys_eim_wr = 1'b1; sys_eim_addr = 17'h0_4020; sys_write_data = 32'h01010101;
    @(negedge clk);
    sys_eim_wr = 1'b0;
    check("wr2_first_cs", 32'(seg_cs), 32'h2);
    @(negedge clk);
    check("wr2_gap_cs", 32'(seg_cs), 32'h0);
    sys_eim_wr = 1'b1; sys_eim_addr = 17'h0_8021; sys_write_data = 32'h02020202;
    @(negedge clk);
    sys_eim_wr = 1'b0;
    check("wr2_second_cs", 32'(seg_cs), 32'h4);
    check("wr2_second_data", seg_write_data, 32'h02020202);
    check("wr2_err", 32'(err), 32'h0);

    // Random traffic against the transaction model.
    do_reset();
    env_mem.delete();
    free_at = 0; m_err = 1'b0; m_cnt = 0; busy_lo = 1; busy_hi = 0; last_rd = '0;
    for (int c = 0; c < 3010; c++) begin
      oh = x_cs.exists(c) ? x_cs[c] : 4'h0;
      check($sformatf("rand_cs@%0d", c), 32'(seg_cs), 32'(oh));
      if (x_cs.exists(c)) begin
        check($sformatf("rand_we@%0d", c), 32'(seg_we), 32'(x_we[c]));
        check($sformatf("rand_addr@%0d", c), 32'(seg_addr), 32'(x_addr[c]));
        if (x_we[c]) check($sformatf("rand_wd@%0d", c), seg_write_data, x_wd[c]);
      end
      check($sformatf("rand_valid@%0d", c), 32'(sys_read_valid), x_rd.exists(c) ? 32'd1 : 32'd0);
      if (x_rd.exists(c)) last_rd = x_rd[c];
      check($sformatf("rand_rdata@%0d", c), sys_read_data, last_rd);
      check($sformatf("rand_busy@%0d", c), 32'(busy), (c >= busy_lo && c <= busy_hi) ? 32'd1 : 32'd0);
      check($sformatf("rand_err@%0d", c), 32'(err), 32'(m_err));
      check($sformatf("rand_err_count@%0d", c), 32'(err_count), exp_cnt(m_cnt));

      rw = 1'b0; rr = 1'b0;
      if (c < 3000) begin
        r = int'($urandom_range(0, 9));
        rw = (r < 3) || (r == 6);
        rr = (r >= 3 && r < 6) || (r == 6);
      end
      seg = 3'($urandom_range(0, 4));
      ra = {seg, 14'($urandom_range(0, 15))};
      wdr = $urandom;
      sys_eim_wr = rw; sys_eim_rd = rr; sys_eim_addr = ra; sys_write_data = wdr;

      if (rw || rr) begin
        mapped = int'(seg) < NS;
        key = int'(seg) * 16384 + int'(ra[13:0]);
        oh = '0;
        if (mapped) oh[seg[1:0]] = 1'b1;
        if (c < free_at) ev = 1'b1;
        else begin
          ev = (rw && rr) || !mapped;
          if (mapped) begin
            x_cs[c+1] = oh; x_we[c+1] = rw; x_addr[c+1] = ra[13:0]; x_wd[c+1] = wdr;
          end
          if (rw) begin
            if (mapped) ref_mem[key] = wdr;
            free_at = c + 2;
          end else begin
            x_rd[c+2+RL] = !mapped ? UNMAPPED : (ref_mem.exists(key) ? ref_mem[key] : init_word(key));
            busy_lo = c + 1; busy_hi = c + 1 + RL;
            free_at = c + 2 + RL;
          end
        end
        if (ev) begin
          m_err = 1'b1;
          if (m_cnt < 65535) m_cnt++;
        end
      end
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/eim_segment_bridge.md
Name: eim_segment_bridge

Overview:
- Sits between the EIM bus front-end and the core selector; consumes the single-cycle sys_eim_wr/sys_eim_rd strobes, 17-bit word address and write data.
- Decodes the address into a segment, drives exactly one segment chip-select with a registered address, data and write-enable, and waits a fixed read latency.
- Captures the selected segment's read word and holds it stable on sys_read_data for the EIM read path, flagging protocol errors (overrun, wr/rd collision, unmapped segment).

Parameters:
- NUM_SEGMENTS, 4, number of decoded segments (1..8); seg index = sys_eim_addr[16:14].
- READ_LATENCY, 2, cycles from seg_cs to valid seg_read_data (1..15).
- UNMAPPED_DATA, 32'hDEADBEEF, word returned on reads to a segment index >= NUM_SEGMENTS.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous reset, active-high.
- sys_eim_addr  in  17  word address, valid with wr/rd strobe.
- sys_eim_wr  in  1  one-cycle write request.
- sys_eim_rd  in  1  one-cycle read request.
- sys_write_data  in  32  write word, valid with sys_eim_wr.
- sys_read_data  out  32  captured read word, held until next capture.
- sys_read_valid  out  1  one-cycle pulse when sys_read_data updates.
- busy  out  1  high while a read is in flight.
- err  out  1  sticky error flag, cleared only by sys_rst.
- seg_cs  out  NUM_SEGMENTS  one-hot segment select, one-cycle pulse.
- seg_we  out  1  write-enable qualifying seg_cs.
- seg_addr  out  14  sys_eim_addr[13:0], registered.
- seg_write_data  out  32  registered write word.
- seg_read_data  in  NUM_SEGMENTS*32  concatenated segment read words, segment 0 in LSBs.
- err_count  out  16  error counter (see Optional Feature).

Behaviour:
- Reset: all outputs 0 except sys_read_data = 0; FSM -> IDLE; latency counter 0; err 0.
- FSM states: IDLE, WRITE, READ_WAIT, CAPTURE.
- IDLE + sys_eim_wr (cycle N): register addr/data; N+1: WRITE state, seg_cs one-hot of segment, seg_we=1; N+2: IDLE. Write throughput one per 2 cycles.
- IDLE + sys_eim_rd (cycle N): N+1: READ_WAIT entered, seg_cs pulse, seg_we=0, busy=1; counter loads READ_LATENCY-1, decrements each cycle; at 0 -> CAPTURE. In CAPTURE, sample seg_read_data slice of latched segment; sys_read_data and sys_read_valid update at cycle N+2+READ_LATENCY; busy drops that same cycle; FSM -> IDLE.
- seg_addr/seg_write_data hold last value between accesses.
- Unmapped segment (index >= NUM_SEGMENTS): no seg_cs bit asserted; writes discarded; reads follow same timing and return UNMAPPED_DATA; err set.
- sys_eim_wr and sys_eim_rd same cycle in IDLE: write performed, read dropped, err set.
- Any strobe while not IDLE (overrun): strobe ignored, in-flight access unaffected, err set.
- sys_rst mid-read: access aborted, no sys_read_valid pulse, sys_read_data forced 0.

Optional Feature:
- Macro EIM_SEGMENT_BRIDGE_ERR_CNT_EN.
- Defined: err_count is a 16-bit counter incremented once per error event (overrun, collision, unmapped access; simultaneous events in one cycle count as one), saturating at 16'hFFFF, reset 0.
- Undefined: err_count tied to 16'h0000, no counter flops; err still functional.

Decomposition:
- Shared package eim_bridge_pkg: FSM state typedef (2-bit enum), SEG_MSB=16/SEG_LSB=14 constants, REG_ADDR_W=14, DATA_W=32.
- One sub-module natural: eim_segment_rd_mux (registered NUM_SEGMENTS:1 read-word mux with unmapped default); the FSM stays in the top.

Test Plan:
- Write addr 17'h0_4012, data 32'hCAFEF00D -> next cycle seg_cs=4'b0010, seg_we=1, seg_addr=14'h0012, seg_write_data=32'hCAFEF00D; err=0.
- Read addr 17'h0_C005, segment 3 drives 32'h12345678, READ_LATENCY=2 -> sys_read_valid pulses 4 cycles after strobe, sys_read_data=32'h12345678, busy high 3 cycles.
- Read addr 17'h1_C000 with NUM_SEGMENTS=4 -> no seg_cs, sys_read_data=32'hDEADBEEF after 4 cycles, err=1.
- sys_eim_wr and sys_eim_rd same cycle to segment 1 -> single write on segment 1, no read pulse, err=1; with macro, err_count=1.
- Second rd strobe one cycle after first -> only one seg_cs pulse and one sys_read_valid; err=1.
- sys_rst asserted during READ_WAIT -> busy=0, sys_read_data=0, no sys_read_valid next 10 cycles.
